// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the in-place radix-2 FFT sequencer.
//   N_LOG2   : log2 of transform length
//   DATA_W   : width of each real/imag component
//   BFLY_LAT : clock edges the butterfly needs with stable operands
package fft_pkg;

  localparam int unsigned N_LOG2   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BFLY_LAT = 3;

  localparam int unsigned N      = 1 << N_LOG2;
  localparam int unsigned HALF_N = N / 2;

  // Index widths: stage counts 0..N_LOG2-1, butterfly index 0..N/2-1.
  localparam int unsigned STAGE_W = (N_LOG2 > 2) ? $clog2(N_LOG2) : 1;
  localparam int unsigned K_W     = N_LOG2 - 1;
  localparam int unsigned CNT_W   = (BFLY_LAT > 2) ? $clog2(BFLY_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational DIT address generator: (stage, butterfly) -> operand addresses and twiddle index.
//   stage    : current stage s
//   k        : butterfly index within the stage
//   addr_a_c : address of the upper operand
//   addr_b_c : address of the lower operand (addr_a_c + 2^s)
//   tw_c     : twiddle ROM index
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [K_W-1:0]     k,
  output logic [N_LOG2-1:0]  addr_a_c,
  output logic [N_LOG2-1:0]  addr_b_c,
  output logic [K_W-1:0]     tw_c
);

  logic [N_LOG2-1:0]  half;
  logic [N_LOG2-1:0]  k_ext;
  logic [N_LOG2-1:0]  pos;
  logic [N_LOG2-1:0]  base;
  logic [STAGE_W-1:0] tw_sh;

  // base = group * 2 * half, i.e. the high bits of k shifted up by one place.
  always_comb begin
    half     = N_LOG2'(1) << stage;
    k_ext    = N_LOG2'(k);
    pos      = k_ext & (half - N_LOG2'(1));
    base     = ((k_ext >> stage) << stage) << 1;
    addr_a_c = base | pos;
    addr_b_c = addr_a_c + half;
    tw_sh    = STAGE_W'(N_LOG2 - 1) - stage;
    tw_c     = K_W'(pos << tw_sh);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences a radix-2 DIT butterfly through every stage of an in-place FFT in a dual-port RAM.
//   i_start            : start pulse, accepted only when idle
//   o_busy / o_done    : transform in progress / single-cycle completion pulse
//   o_rd_en, o_we      : RAM read and write strobes (both ports)
//   o_addr_a/b         : operand addresses, shared by read and write-back
//   o_tw_addr          : twiddle ROM index (1-cycle latency, like the RAM)
//   i_rd_*, i_tw_*     : RAM / ROM read data
//   o_bf_*             : registered butterfly operands, held stable through HOLD and WRITE
//   i_bf_*             : butterfly results
//   o_wr_*             : write data, pass-through of i_bf_* while o_we is high
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [N_LOG2-1:0] o_addr_a,
  output logic [N_LOG2-1:0] o_addr_b,
  input  logic [DATA_W-1:0] i_rd_ra,
  input  logic [DATA_W-1:0] i_rd_ca,
  input  logic [DATA_W-1:0] i_rd_rb,
  input  logic [DATA_W-1:0] i_rd_cb,
  output logic [N_LOG2-2:0] o_tw_addr,
  input  logic [DATA_W-1:0] i_tw_r,
  input  logic [DATA_W-1:0] i_tw_c,
  output logic [DATA_W-1:0] o_bf_ra,
  output logic [DATA_W-1:0] o_bf_ca,
  output logic [DATA_W-1:0] o_bf_rb,
  output logic [DATA_W-1:0] o_bf_cb,
  output logic [DATA_W-1:0] o_bf_tw_r,
  output logic [DATA_W-1:0] o_bf_tw_c,
  input  logic [DATA_W-1:0] i_bf_ra,
  input  logic [DATA_W-1:0] i_bf_ca,
  input  logic [DATA_W-1:0] i_bf_rb,
  input  logic [DATA_W-1:0] i_bf_cb,
  output logic              o_we,
  output logic [DATA_W-1:0] o_wr_ra,
  output logic [DATA_W-1:0] o_wr_ca,
  output logic [DATA_W-1:0] o_wr_rb,
  output logic [DATA_W-1:0] o_wr_cb
);

  state_t             state, state_nxt;
  logic [STAGE_W-1:0] stage, stage_nxt;
  logic [K_W-1:0]     k, k_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_LOG2-1:0]  addr_a_c, addr_b_c;
  logic [K_W-1:0]     tw_c;

  // Addresses are generated from the next (stage, k) so they can be registered on entry to READ.
  fft_addr_gen u_addr_gen (
    .stage    (stage_nxt),
    .k        (k_nxt),
    .addr_a_c (addr_a_c),
    .addr_b_c (addr_b_c),
    .tw_c     (tw_c)
  );

  // Next-state and index update.
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    k_nxt     = k;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_LOAD;
      ST_LOAD: begin
        cnt_nxt   = CNT_W'(BFLY_LAT - 1);
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt == '0) state_nxt = ST_WRITE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_WRITE: begin
        if (k != K_W'(HALF_N - 1)) begin
          k_nxt     = k + K_W'(1);
          state_nxt = ST_READ;
        end else if (stage != STAGE_W'(N_LOG2 - 1)) begin
          stage_nxt = stage + STAGE_W'(1);
          k_nxt     = '0;
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        stage_nxt = '0;
        k_nxt     = '0;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, indices and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      stage     <= '0;
      k         <= '0;
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rd_en   <= 1'b0;
      o_we      <= 1'b0;
      o_addr_a  <= '0;
      o_addr_b  <= '0;
      o_tw_addr <= '0;
      o_bf_ra   <= '0;
      o_bf_ca   <= '0;
      o_bf_rb   <= '0;
      o_bf_cb   <= '0;
      o_bf_tw_r <= '0;
      o_bf_tw_c <= '0;
    end else begin
      state   <= state_nxt;
      stage   <= stage_nxt;
      k       <= k_nxt;
      cnt     <= cnt_nxt;
      o_busy  <= (state_nxt != ST_IDLE);
      o_done  <= (state_nxt == ST_DONE);
      o_rd_en <= (state_nxt == ST_READ);
      o_we    <= (state_nxt == ST_WRITE);
      if (state_nxt == ST_READ) begin
        o_addr_a  <= addr_a_c;
        o_addr_b  <= addr_b_c;
        o_tw_addr <= tw_c;
      end
      // RAM/ROM data arrive during LOAD, one cycle after the read strobe.
      if (state == ST_LOAD) begin
        o_bf_ra   <= i_rd_ra;
        o_bf_ca   <= i_rd_ca;
        o_bf_rb   <= i_rd_rb;
        o_bf_cb   <= i_rd_cb;
        o_bf_tw_r <= i_tw_r;
        o_bf_tw_c <= i_tw_c;
      end
    end
  end

  // Write data follows the butterfly directly, gated to zero outside the write strobe.
  assign o_wr_ra = o_we ? i_bf_ra : '0;
  assign o_wr_ca = o_we ? i_bf_ca : '0;
  assign o_wr_rb = o_we ? i_bf_rb : '0;
  assign o_wr_cb = o_we ? i_bf_cb : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: RAM, twiddle ROM and 3-deep butterfly models around the DUT.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int DONE_CYC = 73;
  localparam int NBF      = 12;

  logic        clk, rst_n, i_start;
  logic        o_busy, o_done, o_rd_en, o_we;
  logic [2:0]  o_addr_a, o_addr_b;
  logic [1:0]  o_tw_addr;
  logic [15:0] i_rd_ra, i_rd_ca, i_rd_rb, i_rd_cb, i_tw_r, i_tw_c;
  logic [15:0] o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c;
  logic [15:0] i_bf_ra, i_bf_ca, i_bf_rb, i_bf_cb;
  logic [15:0] o_wr_ra, o_wr_ca, o_wr_rb, o_wr_cb;

  fft_stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
    .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
    .i_rd_ra(i_rd_ra), .i_rd_ca(i_rd_ca), .i_rd_rb(i_rd_rb), .i_rd_cb(i_rd_cb),
    .o_tw_addr(o_tw_addr), .i_tw_r(i_tw_r), .i_tw_c(i_tw_c),
    .o_bf_ra(o_bf_ra), .o_bf_ca(o_bf_ca), .o_bf_rb(o_bf_rb), .o_bf_cb(o_bf_cb),
    .o_bf_tw_r(o_bf_tw_r), .o_bf_tw_c(o_bf_tw_c),
    .i_bf_ra(i_bf_ra), .i_bf_ca(i_bf_ca), .i_bf_rb(i_bf_rb), .i_bf_cb(i_bf_cb),
    .o_we(o_we),
    .o_wr_ra(o_wr_ra), .o_wr_ca(o_wr_ca), .o_wr_rb(o_wr_rb), .o_wr_cb(o_wr_cb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // W8^t = cos(2*pi*t/8) - j*sin(2*pi*t/8) in Q1.15
  logic [15:0] rom_r [0:3] = '{16'h7FFF, 16'h5A82, 16'h0000, 16'hA57E};
  logic [15:0] rom_c [0:3] = '{16'h0000, 16'hA57E, 16'h8001, 16'hA57E};

  logic [15:0] ram_r [0:7], ram_c [0:7];
  logic [15:0] init_r [0:7], init_c [0:7];
  logic [15:0] gold_r [0:7], gold_c [0:7];
  logic        load;

  function automatic logic [63:0] bfly(input logic [15:0] ar, ac, br, bc, tr, tc);
    longint pr, pc;
    logic [15:0] wr, wc;
    pr = longint'($signed(tr)) * longint'($signed(br)) - longint'($signed(tc)) * longint'($signed(bc));
    pc = longint'($signed(tr)) * longint'($signed(bc)) + longint'($signed(tc)) * longint'($signed(br));
    wr = 16'(pr >>> 15);
    wc = 16'(pc >>> 15);
    return {16'(ar + wr), 16'(ac + wc), 16'(ar - wr), 16'(ac - wc)};
  endfunction

  // Sample RAM and twiddle ROM, 1-cycle read latency, write-back on o_we.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        ram_r[i] <= init_r[i];
        ram_c[i] <= init_c[i];
      end
    end else if (o_we) begin
      ram_r[o_addr_a] <= o_wr_ra;
      ram_c[o_addr_a] <= o_wr_ca;
      ram_r[o_addr_b] <= o_wr_rb;
      ram_c[o_addr_b] <= o_wr_cb;
    end
    if (o_rd_en) begin
      i_rd_ra <= ram_r[o_addr_a];
      i_rd_ca <= ram_c[o_addr_a];
      i_rd_rb <= ram_r[o_addr_b];
      i_rd_cb <= ram_c[o_addr_b];
      i_tw_r  <= rom_r[o_tw_addr];
      i_tw_c  <= rom_c[o_tw_addr];
    end
  end

  // Butterfly with three pipeline registers: result valid after three edges of stable input.
  logic [63:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= bfly(o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c);
    p2 <= p1;
    p3 <= p2;
  end
  assign {i_bf_ra, i_bf_ca, i_bf_rb, i_bf_cb} = p3;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         stage;
    int         k;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    int         we_cyc;
  } vec_t;
  vec_t vecs [NBF];

  // Reference FFT written as the textbook group/position loop.
  task automatic golden();
    logic [63:0] r;
    int half, a, b, t;
    for (int i = 0; i < 8; i++) begin
      gold_r[i] = init_r[i];
      gold_c[i] = init_c[i];
    end
    for (int s = 0; s < 3; s++) begin
      half = 1 << s;
      for (int base = 0; base < 8; base += 2 * half)
        for (int p = 0; p < half; p++) begin
          a = base + p;
          b = a + half;
          t = p * (8 / (2 * half));
          r = bfly(gold_r[a], gold_c[a], gold_r[b], gold_c[b], rom_r[t], rom_c[t]);
          {gold_r[a], gold_c[a], gold_r[b], gold_c[b]} = r;
        end
    end
  endtask

  task automatic load_ram();
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) begin
      init_r[i] = 16'($urandom_range(0, 8191)) - 16'd4096;
      init_c[i] = 16'($urandom_range(0, 8191)) - 16'd4096;
    end
    golden();
    load_ram();
  endtask

  task automatic check_gold(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_re[%0d]", tag, i), ram_r[i], gold_r[i]);
      check($sformatf("%s_im[%0d]", tag, i), ram_c[i], gold_c[i]);
    end
  endtask

  // Runs one transform, checking busy, write-cycle addresses/timing and operand stability per cycle.
  task automatic run_xform(input int extra_start, input int stop_at, input bit hold_start,
                           input int max_cyc, output int done_cyc, output int n_done, output int n_we);
    logic [95:0] h1, h2, h3, cur;
    logic        exp_busy;
    done_cyc = 0; n_done = 0; n_we = 0;
    h1 = '0; h2 = '0; h3 = '0;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (extra_start != 0 && cyc == extra_start) i_start = 1'b1;
      else if (!hold_start)                     i_start = 1'b0;
      cur = {o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c};
      exp_busy = (cyc <= DONE_CYC) || (hold_start && cyc >= DONE_CYC + 2);
      check($sformatf("busy@%0d", cyc), o_busy, exp_busy);
      if (o_we) begin
        if (n_we < NBF) begin
          check($sformatf("addr_a bf%0d", n_we), o_addr_a, vecs[n_we].a);
          check($sformatf("addr_b bf%0d", n_we), o_addr_b, vecs[n_we].b);
          check($sformatf("tw bf%0d", n_we), o_tw_addr, vecs[n_we].tw);
          check($sformatf("we_cycle bf%0d", n_we), cyc, vecs[n_we].we_cyc);
          check($sformatf("hold_stable bf%0d", n_we), {h1 ^ cur, h2 ^ cur, h3 ^ cur}, '0);
        end
        n_we++;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
      h3 = h2; h2 = h1; h1 = cur;
      if (cyc == stop_at) break;
    end
  endtask

  initial begin
    int dc, nd, nw;
    int bf;
    bf = 0;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 4; k++) begin
        vecs[bf].stage  = s;
        vecs[bf].k      = k;
        vecs[bf].we_cyc = 6 * bf + 6;
        bf++;
      end
    vecs[0].a  = 3'd0; vecs[0].b  = 3'd1; vecs[0].tw  = 2'd0;
    vecs[1].a  = 3'd2; vecs[1].b  = 3'd3; vecs[1].tw  = 2'd0;
    vecs[2].a  = 3'd4; vecs[2].b  = 3'd5; vecs[2].tw  = 2'd0;
    vecs[3].a  = 3'd6; vecs[3].b  = 3'd7; vecs[3].tw  = 2'd0;
    vecs[4].a  = 3'd0; vecs[4].b  = 3'd2; vecs[4].tw  = 2'd0;
    vecs[5].a  = 3'd1; vecs[5].b  = 3'd3; vecs[5].tw  = 2'd2;
    vecs[6].a  = 3'd4; vecs[6].b  = 3'd6; vecs[6].tw  = 2'd0;
    vecs[7].a  = 3'd5; vecs[7].b  = 3'd7; vecs[7].tw  = 2'd2;
    vecs[8].a  = 3'd0; vecs[8].b  = 3'd4; vecs[8].tw  = 2'd0;
    vecs[9].a  = 3'd1; vecs[9].b  = 3'd5; vecs[9].tw  = 2'd1;
    vecs[10].a = 3'd2; vecs[10].b = 3'd6; vecs[10].tw = 2'd2;
    vecs[11].a = 3'd3; vecs[11].b = 3'd7; vecs[11].tw = 2'd3;

    rst_n = 1'b1; i_start = 1'b0; load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      init_r[i] = '0;
      init_c[i] = '0;
    end

    // Asynchronous reset asserted mid-cycle.
    #7 rst_n = 1'b0;
    #1;
    check("rst_strobes", {o_busy, o_done, o_rd_en, o_we}, '0);
    check("rst_addr", {o_addr_a, o_addr_b, o_tw_addr}, '0);
    check("rst_bf", {o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c}, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 check($sformatf("idle_busy@%0d", c), {o_busy, o_rd_en, o_we}, '0);
    end

    // Impulse with a start pulse at cycle 20 that must be ignored.
    init_r[0] = 16'h7FFF;
    load_ram();
    run_xform(20, 0, 1'b0, 80, dc, nd, nw);
    check("imp_done_cyc", dc, DONE_CYC);
    check("imp_n_done", nd, 1);
    check("imp_n_we", nw, NBF);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("imp_re[%0d]", i), ram_r[i], 16'h7FFF);
      check($sformatf("imp_im[%0d]", i), ram_c[i], 16'h0000);
    end

    // Random data against the reference transform.
    load_random();
    run_xform(0, 0, 1'b0, 80, dc, nd, nw);
    check("rnd_done_cyc", dc, DONE_CYC);
    check("rnd_n_we", nw, NBF);
    check_gold("rnd");

    // Reset in the middle of a write-back cycle.
    load_random();
    run_xform(0, 30, 1'b0, 80, dc, nd, nw);
    check("pre_rst_we", o_we, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {o_busy, o_done, o_rd_en, o_we}, '0);
    check("mid_rst_addr", {o_addr_a, o_addr_b, o_tw_addr}, '0);
    check("mid_rst_bf", {o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    nw = 0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk);
      #1;
      if (o_done) nd++;
      if (o_busy || o_we) nw++;
    end
    check("post_rst_done", nd, 0);
    check("post_rst_active", nw, 0);
    load_random();
    run_xform(0, 0, 1'b0, 80, dc, nd, nw);
    check("fresh_done_cyc", dc, DONE_CYC);
    check("fresh_n_done", nd, 1);
    check_gold("fresh");

    // Start held high through DONE: one idle cycle, then a new transform.
    run_xform(0, 0, 1'b1, 76, dc, nd, nw);
    check("hold_done_cyc", dc, DONE_CYC);
    check("hold_rd_en", o_rd_en, 1'b0);
    i_start = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
